branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Sequences the decode-stage branch predictor against execute-stage resolution. Decode pushes each prediction into a small in-order in-flight queue. When execute resolves the oldest branch, the block compares actual and predicted outcomes. It then issues the predictor counter update, and on a mispredict drives the PC redirect, IF/ID and ID/EX flushes and a fixed-length recovery sequence. It sits between the decode stage, the branch/jump unit in execute and the PC mux.

Parameters:
DEPTH, 4, in-flight queue entries (power of 2, >=2)
ADDR_W, 32, PC/address width
BR_W, 4, branch-type code width (codes 0-7 valid)
FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict (>=1)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a branch whose prediction is being issued
id_br  in  BR_W  branch-type code of the decode branch
id_pred_taken  in  1  predictor's taken decision (BranchPredictSel)
id_pcplus4  in  ADDR_W  fall-through address
id_target  in  ADDR_W  taken target (PCPlus4+IMM)
ex_resolve_valid  in  1  execute resolves the oldest in-flight branch this cycle
ex_actual_taken  in  1  actual outcome (BranchMux)
id_stall_req  out  1  queue full; decode must hold
pc_redirect_valid  out  1  PC mux must load pc_redirect_addr
pc_redirect_addr  out  ADDR_W  corrected fetch address
flush_ifid  out  1  squash IF/ID register
flush_idex  out  1  squash ID/EX register
upd_valid  out  1  predictor counter update strobe
upd_br  out  BR_W  counter to update
upd_taken  out  1  actual outcome for update
recovering  out  1  state is RECOVER
err_underflow  out  1  sticky: resolve with empty queue
mispredict_cnt  out  CNT_W  saturating mispredict count
resolve_cnt  out  CNT_W  saturating resolved-branch count

Behaviour:
- Reset (synchronous, active-high) clears the queue (ptrs=0, count=0), sets state IDLE and drives all outputs to 0, including both counters and err_underflow. Reset mid-recovery aborts recovery immediately.
- Queue entry fields: {br, pred_taken, pcplus4, target}. FIFO order, wrap-around pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- Push: id_valid & state==IDLE & (count<DEPTH, or a pop occurs this cycle). id_valid while full with no pop: no push, id_stall_req=1.
- id_stall_req is combinational: count==DEPTH & !ex_resolve_valid.
- Pop: ex_resolve_valid & count>0. If count==0: ignore, set err_underflow (sticky until reset).
- Simultaneous push+pop: count unchanged, both pointers advance.
- On pop (registered outputs, 1-cycle latency): upd_valid=1, upd_br=entry.br, upd_taken=ex_actual_taken for exactly one cycle. resolve_cnt+1 (saturates at all-ones).
- Mispredict = entry.pred_taken != ex_actual_taken. Effects:
  - next cycle pc_redirect_valid=1 for one cycle;
  - pc_redirect_addr = actual ? entry.target : entry.pcplus4;
  - mispredict_cnt+1, saturating;
  - entire queue cleared (younger entries are wrong-path), overriding any same-cycle push;
  - state goes to RECOVER.
- State machine IDLE/RECOVER:
  - IDLE -> RECOVER on mispredict.
  - In RECOVER, flush_ifid=flush_idex=1 and recovering=1 for FLUSH_CYCLES cycles, starting the cycle pc_redirect_valid asserts; a down-counter tracks this.
  - In RECOVER, pushes and resolves are ignored (no update, no err).
  - RECOVER -> IDLE when the counter reaches 0.
- Correct prediction: no redirect, no flush, state unchanged.
- Outputs not listed as combinational are registered.

Decomposition:
- Shared package bp_pkg: branch code constants (BR_BEQ=0 … BR_BGEZAL=7), queue entry struct/width, state enum {IDLE, RECOVER}.
- One natural sub-module: bp_inflight_fifo (parameterised DEPTH/width, push/pop/clear, full/empty/count).
- Compare, FSM and counters stay in the top.

Test Plan:
- Reset then push BEQ, pred=1, pcplus4=0x104, target=0x200; resolve actual=1 -> next cycle upd_valid=1, upd_br=0, upd_taken=1; no redirect; resolve_cnt=1.
- Push BNE, pred=0, pcplus4=0x304, target=0x400; resolve actual=1 -> pc_redirect_valid=1 with addr 0x400 for one cycle; flush_ifid/idex high 2 cycles; mispredict_cnt=1.
- Push 4 entries without resolve -> id_stall_req=1, 5th push dropped; same-cycle push+resolve -> count stays 4, stall low.
- Push 3 entries; mispredict on oldest with id_valid same cycle -> queue count 0 after; pushes during RECOVER ignored; push accepted first IDLE cycle.
- Resolve with empty queue -> err_underflow=1 and sticky; no upd_valid; reset clears it.
- Assert reset during RECOVER cycle 1 -> next cycle flush/recovering=0, counters 0; force 65536 mispredicts -> mispredict_cnt holds 0xFFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolution controller: branch codes,
// in-flight queue entry layout and the recovery state encoding.
package bp_pkg;

  localparam int unsigned BR_BEQ    = 0;
  localparam int unsigned BR_BNE    = 1;
  localparam int unsigned BR_BLEZ   = 2;
  localparam int unsigned BR_BGTZ   = 3;
  localparam int unsigned BR_BLTZ   = 4;
  localparam int unsigned BR_BGEZ   = 5;
  localparam int unsigned BR_BLTZAL = 6;
  localparam int unsigned BR_BGEZAL = 7;

  localparam int unsigned BP_ADDR_W = 32;
  localparam int unsigned BP_BR_W   = 4;

  // Reference layout at the default widths; the top packs the same field
  // order generically so non-default widths keep working.
  typedef struct packed {
    logic [BP_BR_W-1:0]   br;
    logic                 pred_taken;
    logic [BP_ADDR_W-1:0] pcplus4;
    logic [BP_ADDR_W-1:0] target;
  } bp_entry_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned br_w);
    return br_w + 1 + 2 * addr_w;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted branches awaiting resolution in execute.
// Clear wins over a same-cycle push; push into a full queue needs a pop.
module bp_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after a push
  // wrote it, and leaving the array reset-free lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks decode-stage predictions until execute resolves them, updates the
// predictor and on a mispredict redirects the PC and runs a flush sequence.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BR_W         = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [BR_W-1:0]   id_br,
  input  logic              id_pred_taken,
  input  logic [ADDR_W-1:0] id_pcplus4,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              ex_resolve_valid,
  input  logic              ex_actual_taken,
  output logic              id_stall_req,
  output logic              pc_redirect_valid,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              upd_valid,
  output logic [BR_W-1:0]   upd_br,
  output logic              upd_taken,
  output logic              recovering,
  output logic              err_underflow,
  output logic [CNT_W-1:0]  mispredict_cnt,
  output logic [CNT_W-1:0]  resolve_cnt
);

  localparam int unsigned ENTRY_W = entry_width(ADDR_W, BR_W);
  localparam int unsigned FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  bp_state_e         state_q, state_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              pc_redirect_valid_q, pc_redirect_valid_d;
  logic [ADDR_W-1:0] pc_redirect_addr_q, pc_redirect_addr_d;
  logic              upd_valid_q, upd_valid_d;
  logic [BR_W-1:0]   upd_br_q, upd_br_d;
  logic              upd_taken_q, upd_taken_d;
  logic              err_underflow_q, err_underflow_d;
  logic [CNT_W-1:0]  mispredict_cnt_q, mispredict_cnt_d;
  logic [CNT_W-1:0]  resolve_cnt_q, resolve_cnt_d;

  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic               fifo_full, fifo_empty;
  logic               is_idle, do_pop, do_push, mispredict;
  logic [BR_W-1:0]    head_br;
  logic               head_pred;
  logic [ADDR_W-1:0]  head_pcplus4, head_target;

  assign push_entry   = {id_br, id_pred_taken, id_pcplus4, id_target};
  assign head_target  = head_entry[ADDR_W-1:0];
  assign head_pcplus4 = head_entry[2*ADDR_W-1:ADDR_W];
  assign head_pred    = head_entry[2*ADDR_W];
  assign head_br      = head_entry[ENTRY_W-1 -: BR_W];

  // Decode and execute are both ignored while recovery is in progress.
  assign is_idle    = (state_q == IDLE);
  assign do_pop     = ex_resolve_valid & is_idle & ~fifo_empty;
  assign do_push    = id_valid & is_idle & (~fifo_full | do_pop);
  assign mispredict = do_pop & (head_pred != ex_actual_taken);

  assign id_stall_req = fifo_full & ~ex_resolve_valid;

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (do_push),
    .pop     (do_pop),
    .clear   (mispredict),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    pc_redirect_valid_d = mispredict;
    pc_redirect_addr_d  = pc_redirect_addr_q;
    upd_valid_d         = do_pop;
    upd_br_d            = upd_br_q;
    upd_taken_d         = upd_taken_q;
    err_underflow_d     = err_underflow_q | (ex_resolve_valid & is_idle & fifo_empty);
    mispredict_cnt_d    = mispredict_cnt_q;
    resolve_cnt_d       = resolve_cnt_q;

    if (do_pop) begin
      upd_br_d    = head_br;
      upd_taken_d = ex_actual_taken;
      if (resolve_cnt_q != '1) resolve_cnt_d = resolve_cnt_q + CNT_W'(1);
    end
    if (mispredict) begin
      pc_redirect_addr_d = ex_actual_taken ? head_target : head_pcplus4;
      if (mispredict_cnt_q != '1) mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
    end
  end

  // The counter holds the number of RECOVER cycles left after this one.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d     = RECOVER;
          flush_cnt_d = FC_LOAD;
        end
      end
      RECOVER: begin
        if (flush_cnt_q == '0) state_d = IDLE;
        else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      flush_cnt_q         <= '0;
      pc_redirect_valid_q <= 1'b0;
      pc_redirect_addr_q  <= '0;
      upd_valid_q         <= 1'b0;
      upd_br_q            <= '0;
      upd_taken_q         <= 1'b0;
      err_underflow_q     <= 1'b0;
      mispredict_cnt_q    <= '0;
      resolve_cnt_q       <= '0;
    end else begin
      state_q             <= state_d;
      flush_cnt_q         <= flush_cnt_d;
      pc_redirect_valid_q <= pc_redirect_valid_d;
      pc_redirect_addr_q  <= pc_redirect_addr_d;
      upd_valid_q         <= upd_valid_d;
      upd_br_q            <= upd_br_d;
      upd_taken_q         <= upd_taken_d;
      err_underflow_q     <= err_underflow_d;
      mispredict_cnt_q    <= mispredict_cnt_d;
      resolve_cnt_q       <= resolve_cnt_d;
    end
  end

  assign pc_redirect_valid = pc_redirect_valid_q;
  assign pc_redirect_addr  = pc_redirect_addr_q;
  assign upd_valid         = upd_valid_q;
  assign upd_br            = upd_br_q;
  assign upd_taken         = upd_taken_q;
  assign err_underflow     = err_underflow_q;
  assign mispredict_cnt    = mispredict_cnt_q;
  assign resolve_cnt       = resolve_cnt_q;
  assign recovering        = (state_q == RECOVER);
  assign flush_ifid        = recovering;
  assign flush_idex        = recovering;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_resolve_ctrl;
  import bp_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int BR_W   = 4;
  localparam int FC     = 2;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              id_valid = 1'b0;
  logic [BR_W-1:0]   id_br = '0;
  logic              id_pred_taken = 1'b0;
  logic [ADDR_W-1:0] id_pcplus4 = '0;
  logic [ADDR_W-1:0] id_target = '0;
  logic              ex_resolve_valid = 1'b0;
  logic              ex_actual_taken = 1'b0;
  logic              id_stall_req, pc_redirect_valid, flush_ifid, flush_idex;
  logic [ADDR_W-1:0] pc_redirect_addr;
  logic              upd_valid, upd_taken, recovering, err_underflow;
  logic [BR_W-1:0]   upd_br;
  logic [CNT_W-1:0]  mispredict_cnt, resolve_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BR_W(BR_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_br(id_br),
    .id_pred_taken(id_pred_taken), .id_pcplus4(id_pcplus4), .id_target(id_target),
    .ex_resolve_valid(ex_resolve_valid), .ex_actual_taken(ex_actual_taken),
    .id_stall_req(id_stall_req), .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect_addr(pc_redirect_addr), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .upd_valid(upd_valid), .upd_br(upd_br), .upd_taken(upd_taken),
    .recovering(recovering), .err_underflow(err_underflow),
    .mispredict_cnt(mispredict_cnt), .resolve_cnt(resolve_cnt)
  );

  // Reference model: in-flight branches as a queue, recovery as cycles left.
  typedef struct {
    logic [BR_W-1:0]   br;
    logic              pred;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] tgt;
  } ent_t;

  ent_t              mq[$];
  int                m_rec = 0;
  bit                m_err = 0;
  int                m_mcnt = 0, m_rcnt = 0;
  bit                m_upd = 0, m_redir = 0, m_upd_taken = 0;
  logic [BR_W-1:0]   m_upd_br = '0;
  logic [ADDR_W-1:0] m_addr = '0;

  task automatic model_step();
    ent_t e;
    bit   popped, pushed;
    m_upd   = 0;
    m_redir = 0;
    if (reset) begin
      mq.delete();
      m_rec = 0; m_err = 0; m_mcnt = 0; m_rcnt = 0;
      return;
    end
    if (m_rec > 0) begin
      m_rec--;
      return;
    end
    popped = ex_resolve_valid && (mq.size() > 0);
    pushed = id_valid && ((mq.size() < DEPTH) || popped);
    if (ex_resolve_valid && mq.size() == 0) m_err = 1;
    if (popped) begin
      e = mq.pop_front();
      m_upd       = 1;
      m_upd_br    = e.br;
      m_upd_taken = ex_actual_taken;
      if (m_rcnt < CMAX) m_rcnt++;
      if (e.pred != ex_actual_taken) begin
        m_redir = 1;
        m_addr  = ex_actual_taken ? e.tgt : e.pc4;
        if (m_mcnt < CMAX) m_mcnt++;
        mq.delete();
        m_rec  = FC;
        pushed = 0;
      end
    end
    if (pushed) mq.push_back('{id_br, id_pred_taken, id_pcplus4, id_target});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input int br, input bit pred,
                       input logic [ADDR_W-1:0] pc4, input logic [ADDR_W-1:0] tgt,
                       input bit rv, input bit act);
    id_valid         = iv;
    id_br            = BR_W'(br);
    id_pred_taken    = pred;
    id_pcplus4       = pc4;
    id_target        = tgt;
    ex_resolve_valid = rv;
    ex_actual_taken  = act;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    cycle();
    cycle();
    total++; if ({pc_redirect_valid, flush_ifid, flush_idex, upd_valid, recovering, err_underflow} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {pc_redirect_valid, flush_ifid, flush_idex, upd_valid, recovering, err_underflow}); end
    total++; if ({mispredict_cnt, resolve_cnt} !== '0) begin bad++; $display("FAIL reset_cnts got=%0h/%0h exp=0/0", mispredict_cnt, resolve_cnt); end
    total++; if ({pc_redirect_addr, upd_br, upd_taken} !== '0) begin bad++; $display("FAIL reset_data got=%0h/%0h/%0b exp=0", pc_redirect_addr, upd_br, upd_taken); end
    total++; if (id_stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", id_stall_req); end
    reset = 1'b0;
  endtask

  task automatic test_predict_hit();
    drive(1, BR_BEQ, 1, 32'h104, 32'h200, 0, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 1, 1);
    cycle();
    total++; if (upd_valid !== 1'b1) begin bad++; $display("FAIL hit_upd_valid got=%b exp=1", upd_valid); end
    total++; if (upd_br !== 4'd0) begin bad++; $display("FAIL hit_upd_br got=%0d exp=0", upd_br); end
    total++; if (upd_taken !== 1'b1) begin bad++; $display("FAIL hit_upd_taken got=%b exp=1", upd_taken); end
    total++; if ({pc_redirect_valid, recovering, flush_ifid} !== 3'b000) begin bad++; $display("FAIL hit_no_redirect got=%b exp=000", {pc_redirect_valid, recovering, flush_ifid}); end
    total++; if (resolve_cnt !== 8'd1) begin bad++; $display("FAIL hit_resolve_cnt got=%0d exp=1", resolve_cnt); end
    idle();
    cycle();
    total++; if (upd_valid !== 1'b0) begin bad++; $display("FAIL hit_upd_pulse got=%b exp=0", upd_valid); end
  endtask

  task automatic test_mispredict();
    drive(1, BR_BNE, 0, 32'h304, 32'h400, 0, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 1, 1);
    cycle();
    total++; if (pc_redirect_valid !== 1'b1) begin bad++; $display("FAIL mis_redirect got=%b exp=1", pc_redirect_valid); end
    total++; if (pc_redirect_addr !== 32'h400) begin bad++; $display("FAIL mis_addr got=%0h exp=400", pc_redirect_addr); end
    total++; if ({flush_ifid, flush_idex, recovering} !== 3'b111) begin bad++; $display("FAIL mis_flush1 got=%b exp=111", {flush_ifid, flush_idex, recovering}); end
    total++; if (mispredict_cnt !== 8'd1) begin bad++; $display("FAIL mis_cnt got=%0d exp=1", mispredict_cnt); end
    total++; if ({upd_valid, upd_br, upd_taken} !== {1'b1, 4'd1, 1'b1}) begin bad++; $display("FAIL mis_upd got=%b/%0d/%b exp=1/1/1", upd_valid, upd_br, upd_taken); end
    idle();
    cycle();
    total++; if (pc_redirect_valid !== 1'b0) begin bad++; $display("FAIL mis_redirect_pulse got=%b exp=0", pc_redirect_valid); end
    total++; if ({flush_ifid, flush_idex} !== 2'b11) begin bad++; $display("FAIL mis_flush2 got=%b exp=11", {flush_ifid, flush_idex}); end
    cycle();
    total++; if ({flush_ifid, flush_idex, recovering} !== 3'b000) begin bad++; $display("FAIL mis_flush_end got=%b exp=000", {flush_ifid, flush_idex, recovering}); end
  endtask

  task automatic test_full_stall();
    int exp_br[5] = '{1, 2, 3, 4, 6};
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 1, 32'h1000 + i, 32'h2000 + i, 0, 0);
      cycle();
    end
    drive(1, 5, 1, 32'h1005, 32'h2005, 0, 0);
    #1;
    total++; if (id_stall_req !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", id_stall_req); end
    cycle();
    drive(1, 6, 1, 32'h1006, 32'h2006, 1, 1);
    #1;
    total++; if (id_stall_req !== 1'b0) begin bad++; $display("FAIL full_stall_pop got=%b exp=0", id_stall_req); end
    cycle();
    total++; if ({upd_valid, upd_br} !== {1'b1, BR_W'(exp_br[0])}) begin bad++; $display("FAIL full_pushpop_upd got=%b/%0d exp=1/%0d", upd_valid, upd_br, exp_br[0]); end
    idle();
    #1;
    total++; if (id_stall_req !== 1'b1) begin bad++; $display("FAIL full_still4 got=%b exp=1", id_stall_req); end
    for (int i = 1; i < 5; i++) begin
      drive(0, 0, 0, '0, '0, 1, 1);
      cycle();
      total++; if ({upd_valid, upd_br} !== {1'b1, BR_W'(exp_br[i])}) begin bad++; $display("FAIL full_drain%0d got=%b/%0d exp=1/%0d", i, upd_valid, upd_br, exp_br[i]); end
    end
    idle();
    cycle();
  endtask

  task automatic test_recover_push();
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, 0, 32'h3000 + 32'(i * 16), 32'h4000 + 32'(i * 16), 0, 0);
      cycle();
    end
    drive(1, BR_BGEZAL, 1, 32'h5004, 32'h6000, 1, 1);
    cycle();
    total++; if ({pc_redirect_valid, pc_redirect_addr} !== {1'b1, 32'h4000}) begin bad++; $display("FAIL rec_redirect got=%b/%0h exp=1/4000", pc_redirect_valid, pc_redirect_addr); end
    drive(1, BR_BGEZ, 1, 32'h7004, 32'h8000, 1, 0);
    cycle();
    total++; if ({upd_valid, err_underflow, recovering} !== 3'b001) begin bad++; $display("FAIL rec_ignore1 got=%b exp=001", {upd_valid, err_underflow, recovering}); end
    cycle();
    total++; if ({upd_valid, err_underflow, recovering} !== 3'b000) begin bad++; $display("FAIL rec_ignore2 got=%b exp=000", {upd_valid, err_underflow, recovering}); end
    drive(1, BR_BLTZAL, 1, 32'h9004, 32'hA000, 0, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 1, 1);
    cycle();
    total++; if ({upd_valid, upd_br, pc_redirect_valid} !== {1'b1, 4'd6, 1'b0}) begin bad++; $display("FAIL rec_first_idle_push got=%b/%0d/%b exp=1/6/0", upd_valid, upd_br, pc_redirect_valid); end
    cycle();
    total++; if ({err_underflow, upd_valid} !== 2'b10) begin bad++; $display("FAIL rec_queue_emptied got=%b exp=10", {err_underflow, upd_valid}); end
    idle();
  endtask

  task automatic test_underflow();
    reset = 1'b1; idle(); cycle(); reset = 1'b0;
    drive(0, 0, 0, '0, '0, 1, 1);
    cycle();
    total++; if ({err_underflow, upd_valid} !== 2'b10) begin bad++; $display("FAIL uf_set got=%b exp=10", {err_underflow, upd_valid}); end
    total++; if (resolve_cnt !== 8'd0) begin bad++; $display("FAIL uf_resolve_cnt got=%0d exp=0", resolve_cnt); end
    idle();
    cycle();
    cycle();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uf_reset got=%b exp=0", err_underflow); end
  endtask

  task automatic test_reset_in_recover();
    drive(1, BR_BLEZ, 1, 32'h504, 32'h600, 0, 0);
    cycle();
    drive(0, 0, 0, '0, '0, 1, 0);
    cycle();
    total++; if ({recovering, pc_redirect_valid, pc_redirect_addr} !== {2'b11, 32'h504}) begin bad++; $display("FAIL rr_redirect got=%b/%b/%0h exp=1/1/504", recovering, pc_redirect_valid, pc_redirect_addr); end
    reset = 1'b1;
    idle();
    cycle();
    reset = 1'b0;
    total++; if ({flush_ifid, flush_idex, recovering, pc_redirect_valid} !== 4'b0000) begin bad++; $display("FAIL rr_abort got=%b exp=0000", {flush_ifid, flush_idex, recovering, pc_redirect_valid}); end
    total++; if ({mispredict_cnt, resolve_cnt} !== '0) begin bad++; $display("FAIL rr_cnts got=%0d/%0d exp=0/0", mispredict_cnt, resolve_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 40; i++) begin
      drive(1, i % 8, 1, 32'(i), 32'(i) + 32'h100, 0, 0);
      cycle();
      drive(0, 0, 0, '0, '0, 1, 0);
      cycle();
      idle();
      cycle();
      cycle();
    end
    total++; if (mispredict_cnt !== 8'hFF) begin bad++; $display("FAIL sat_mispredict got=%0h exp=ff", mispredict_cnt); end
    total++; if (resolve_cnt !== 8'hFF) begin bad++; $display("FAIL sat_resolve got=%0h exp=ff", resolve_cnt); end
  endtask

  task automatic test_random();
    bit exp_stall;
    reset = 1'b1; idle(); cycle(); reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom, $urandom, $urandom_range(0, 99) < 45, $urandom_range(0, 1));
      #1;
      exp_stall = (mq.size() == DEPTH) && !ex_resolve_valid;
      total++; if (id_stall_req !== exp_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, id_stall_req, exp_stall); end
      cycle();
      total++; if (upd_valid !== m_upd) begin bad++; $display("FAIL rnd_upd_valid n=%0d got=%b exp=%b", n, upd_valid, m_upd); end
      if (m_upd) begin
        total++; if ({upd_br, upd_taken} !== {m_upd_br, m_upd_taken}) begin bad++; $display("FAIL rnd_upd n=%0d got=%0d/%b exp=%0d/%b", n, upd_br, upd_taken, m_upd_br, m_upd_taken); end
      end
      total++; if (pc_redirect_valid !== m_redir) begin bad++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, pc_redirect_valid, m_redir); end
      if (m_redir) begin
        total++; if (pc_redirect_addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%0h exp=%0h", n, pc_redirect_addr, m_addr); end
      end
      total++; if ({recovering, flush_ifid, flush_idex} !== {3{m_rec > 0}}) begin bad++; $display("FAIL rnd_recover n=%0d got=%b exp=%0d", n, {recovering, flush_ifid, flush_idex}, m_rec > 0); end
      total++; if (err_underflow !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err_underflow, m_err); end
      total++; if ({mispredict_cnt, resolve_cnt} !== {CNT_W'(m_mcnt), CNT_W'(m_rcnt)}) begin bad++; $display("FAIL rnd_cnts n=%0d got=%0d/%0d exp=%0d/%0d", n, mispredict_cnt, resolve_cnt, m_mcnt, m_rcnt); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_predict_hit();
    test_mispredict();
    test_full_stall();
    test_recover_push();
    test_underflow();
    test_reset_in_recover();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
